// File: rtl/cluster_feeder_pkg.sv
// Shared definitions for the PE cluster feeder: default geometry, derived
// widths and the sequencer state encoding.
package cluster_feeder_pkg;

  localparam int DEF_DATA_BITWIDTH     = 16;
  localparam int DEF_GLB_ADDR_BITWIDTH = 12;
  localparam int DEF_X_DIM             = 5;
  localparam int DEF_W_COUNT           = 15;
  localparam int DEF_A_COUNT           = 25;
  localparam int DEF_CAP_DELAY         = 1;
  localparam int DEF_TIMEOUT           = 1023;

  localparam int PSUM_BITWIDTH = DEF_DATA_BITWIDTH * DEF_X_DIM;
  localparam int W_CNT_BITS    = $clog2(DEF_W_COUNT + 1);
  localparam int A_CNT_BITS    = $clog2(DEF_A_COUNT + 1);
  localparam int TMO_CNT_BITS  = $clog2(DEF_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_W      = 3'd1,
    S_RD_A      = 3'd2,
    S_WAIT_LOAD = 3'd3,
    S_START     = 3'd4,
    S_WAIT_COMP = 3'd5,
    S_CAPTURE   = 3'd6,
    S_OUT       = 3'd7
  } feeder_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cluster_feeder_glb_stream_reader.sv
// Issues a run of sequential GLB reads from a base address and presents the
// returned words one cycle later as a valid/data pair.
module cluster_feeder_glb_stream_reader #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] glb_rd_data,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          last,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          valid_q, valid_d;

  // A start on the final read of one run chains the next run with no gap.
  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    valid_d  = active_q;
    if (start) begin
      active_d = 1'b1;
      addr_d   = base;
      rem_d    = len - LW'(1);
    end else if (active_q) begin
      if (rem_q == {LW{1'b0}}) begin
        active_d = 1'b0;
      end else begin
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - LW'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      addr_q   <= {AW{1'b0}};
      rem_q    <= {LW{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_en     = active_q;
  assign rd_addr   = addr_q;
  assign last      = active_q && (rem_q == {LW{1'b0}});
  assign out_valid = valid_q;
  assign out_data  = valid_q ? glb_rd_data : {DW{1'b0}};

endmodule

// File: rtl/cluster_feeder.sv
// Feeds one PE cluster: streams weights then activations from the GLB, starts
// the compute, captures the psum vector and hands it out over valid/ready.
module cluster_feeder
  import cluster_feeder_pkg::*;
#(
  parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
  parameter int GLB_ADDR_BITWIDTH = DEF_GLB_ADDR_BITWIDTH,
  parameter int X_dim             = DEF_X_DIM,
  parameter int W_COUNT           = DEF_W_COUNT,
  parameter int A_COUNT           = DEF_A_COUNT,
  parameter int CAP_DELAY         = DEF_CAP_DELAY,
  parameter int TIMEOUT           = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [GLB_ADDR_BITWIDTH-1:0]     cmd_w_base,
  input  logic [GLB_ADDR_BITWIDTH-1:0]     cmd_a_base,
  input  logic                             cmd_acc,
  output logic                             glb_rd_en,
  output logic [GLB_ADDR_BITWIDTH-1:0]     glb_rd_addr,
  input  logic [DATA_BITWIDTH-1:0]         glb_rd_data,
  output logic [DATA_BITWIDTH-1:0]         cl_filt_in,
  output logic [DATA_BITWIDTH-1:0]         cl_act_in,
  output logic                             cl_load_en_wght,
  output logic                             cl_load_en_act,
  output logic                             cl_start,
  output logic [DATA_BITWIDTH*X_dim-1:0]   cl_pe_before,
  input  logic                             cl_load_done,
  input  logic                             cl_compute_done,
  input  logic [DATA_BITWIDTH*X_dim-1:0]   cl_pe_out,
  output logic                             psum_valid,
  input  logic                             psum_ready,
  output logic [DATA_BITWIDTH*X_dim-1:0]   psum_data,
  output logic                             err_timeout
);

  localparam int PW    = DATA_BITWIDTH * X_dim;
  localparam int AW    = GLB_ADDR_BITWIDTH;
  localparam int LEN_W = $clog2(max_int(W_COUNT, A_COUNT) + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CAP_W = $clog2(CAP_DELAY + 1);

  localparam logic [LEN_W-1:0] W_LEN    = LEN_W'(W_COUNT);
  localparam logic [LEN_W-1:0] A_LEN    = LEN_W'(A_COUNT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_DELAY - 1);

  feeder_state_e  state_q, state_d;
  logic [AW-1:0]  a_base_q, a_base_d;
  logic           acc_q, acc_d;
  logic           err_q, err_d;
  logic [PW-1:0]  pe_before_q, pe_before_d;
  logic [PW-1:0]  psum_q, psum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic           act_ph_q, act_ph_d;
  logic           done_prev_q;

  logic             rd_start;
  logic [AW-1:0]    rd_base;
  logic [LEN_W-1:0] rd_len;
  logic             rd_last;
  logic             rd_valid;
  logic [DATA_BITWIDTH-1:0] rd_data;

  cluster_feeder_glb_stream_reader #(
    .DW (DATA_BITWIDTH),
    .AW (AW),
    .LW (LEN_W)
  ) u_reader (
    .clk         (clk),
    .reset       (reset),
    .start       (rd_start),
    .base        (rd_base),
    .len         (rd_len),
    .glb_rd_data (glb_rd_data),
    .rd_en       (glb_rd_en),
    .rd_addr     (glb_rd_addr),
    .last        (rd_last),
    .out_valid   (rd_valid),
    .out_data    (rd_data)
  );

  // Sequencer next-state; the reader is re-armed with the activation run on
  // the last weight read so the two load streams abut.
  always_comb begin
    state_d     = state_q;
    a_base_d    = a_base_q;
    acc_d       = acc_q;
    err_d       = err_q;
    pe_before_d = pe_before_q;
    psum_d      = psum_q;
    tmo_d       = tmo_q;
    cap_d       = cap_q;
    act_ph_d    = (state_q == S_RD_A);
    rd_start    = 1'b0;
    rd_base     = cmd_w_base;
    rd_len      = W_LEN;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_base_d    = cmd_a_base;
          acc_d       = cmd_acc;
          err_d       = 1'b0;
          pe_before_d = cmd_acc ? psum_q : {PW{1'b0}};
          rd_start    = 1'b1;
          state_d     = S_RD_W;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_W: begin
        if (rd_last) begin
          rd_start = 1'b1;
          rd_base  = a_base_q;
          rd_len   = A_LEN;
          state_d  = S_RD_A;
        end else begin
          state_d = S_RD_W;
        end
      end
      S_RD_A: begin
        if (!glb_rd_en && rd_valid) begin
          tmo_d   = {TMO_W{1'b0}};
          state_d = S_WAIT_LOAD;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_WAIT_LOAD: begin
        if (cl_load_done) begin
          state_d = S_START;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_START: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_WAIT_COMP;
      end
      S_WAIT_COMP: begin
        if (cl_compute_done && !done_prev_q) begin
          cap_d   = {CAP_W{1'b0}};
          state_d = S_CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CAPTURE: begin
        if (cap_q == CAP_LAST) begin
          psum_d  = cl_pe_out;
          state_d = S_OUT;
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      S_OUT: begin
        if (psum_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; compute_done is sampled every cycle so the
  // previous value is already valid on the first WAIT_COMP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_base_q    <= {AW{1'b0}};
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      pe_before_q <= {PW{1'b0}};
      psum_q      <= {PW{1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
      cap_q       <= {CAP_W{1'b0}};
      act_ph_q    <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_base_q    <= a_base_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      pe_before_q <= pe_before_d;
      psum_q      <= psum_d;
      tmo_q       <= tmo_d;
      cap_q       <= cap_d;
      act_ph_q    <= act_ph_d;
      done_prev_q <= cl_compute_done;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign cl_start        = (state_q == S_START);
  assign psum_valid      = (state_q == S_OUT);
  assign psum_data       = psum_q;
  assign cl_pe_before    = pe_before_q;
  assign err_timeout     = err_q;
  assign cl_load_en_wght = rd_valid && !act_ph_q;
  assign cl_load_en_act  = rd_valid && act_ph_q;
  assign cl_filt_in      = cl_load_en_wght ? rd_data : {DATA_BITWIDTH{1'b0}};
  assign cl_act_in       = cl_load_en_act ? rd_data : {DATA_BITWIDTH{1'b0}};

endmodule

// File: tb/tb_cluster_feeder.sv
// Scoreboard bench for cluster_feeder: stimulus queues expected load words and
// results, negedge monitors compare them against what the DUT presents.
module tb_cluster_feeder;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int PW  = 80;
  localparam int TMO = 1023;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_acc;
  logic [AW-1:0] cmd_w_base, cmd_a_base;
  logic          glb_rd_en;
  logic [AW-1:0] glb_rd_addr;
  logic [DW-1:0] glb_rd_data;
  logic [DW-1:0] cl_filt_in, cl_act_in;
  logic          cl_load_en_wght, cl_load_en_act, cl_start;
  logic [PW-1:0] cl_pe_before, cl_pe_out, psum_data;
  logic          cl_load_done, cl_compute_done;
  logic          psum_valid, psum_ready, err_timeout;

  cluster_feeder dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_base(cmd_w_base), .cmd_a_base(cmd_a_base), .cmd_acc(cmd_acc),
    .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr), .glb_rd_data(glb_rd_data),
    .cl_filt_in(cl_filt_in), .cl_act_in(cl_act_in),
    .cl_load_en_wght(cl_load_en_wght), .cl_load_en_act(cl_load_en_act),
    .cl_start(cl_start), .cl_pe_before(cl_pe_before),
    .cl_load_done(cl_load_done), .cl_compute_done(cl_compute_done),
    .cl_pe_out(cl_pe_out),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB model: the word stored at address a is a itself, one cycle latency.
  always @(posedge clk) glb_rd_data <= {4'h0, glb_rd_addr};

  typedef struct packed {
    logic          is_act;
    logic [DW-1:0] data;
  } sw_t;

  sw_t           stream_q[$];
  logic [PW-1:0] psum_q[$];
  logic [PW-1:0] exp_pe_before;
  logic [PW-1:0] last_result;
  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not seen within its cycle budget", name);
  endtask

  function automatic logic [PW-1:0] pack5(input logic [DW-1:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // Monitor: load-stream scoreboard, gating and pe_before, start counting, psum transfers.
  always @(negedge clk) begin
    sw_t e;
    logic [PW-1:0] r;
    if (cl_start) start_cnt++;
    if (cl_load_en_wght && cl_load_en_act) fail_now("en_exclusive");
    if (!cl_load_en_wght) check("filt_gated", cl_filt_in, '0);
    if (!cl_load_en_act) check("act_gated", cl_act_in, '0);
    if (cl_load_en_wght || cl_load_en_act) begin
      if (stream_q.size() == 0) begin
        fail_now("stream_extra");
      end else begin
        e = stream_q.pop_front();
        check("stream_phase", cl_load_en_act, e.is_act);
        check("stream_data", cl_load_en_act ? cl_act_in : cl_filt_in, e.data);
        check("pe_before", cl_pe_before, exp_pe_before);
      end
    end
    if (psum_valid && psum_ready) begin
      if (psum_q.size() == 0) begin
        fail_now("psum_extra");
      end else begin
        r = psum_q.pop_front();
        check("psum_data", psum_data, r);
      end
    end
  end

  task automatic push_stream(input logic [AW-1:0] w, input logic [AW-1:0] a);
    sw_t e;
    logic [AW-1:0] ad;
    for (int k = 0; k < 15; k++) begin
      ad = w + AW'(k);
      e.is_act = 1'b0; e.data = {4'h0, ad};
      stream_q.push_back(e);
    end
    for (int k = 0; k < 25; k++) begin
      ad = a + AW'(k);
      e.is_act = 1'b1; e.data = {4'h0, ad};
      stream_q.push_back(e);
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] w, input logic [AW-1:0] a, input logic acc);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) fail_now("cmd_ready_wait");
    push_stream(w, a);
    exp_pe_before = acc ? last_result : '0;
    cmd_w_base = w; cmd_a_base = a; cmd_acc = acc; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("err_cleared_on_accept", err_timeout, 1'b0);
  endtask

  task automatic wait_stream_drained();
    for (int i = 0; i < 200 && stream_q.size() != 0; i++) @(negedge clk);
    if (stream_q.size() != 0) fail_now("stream_drain");
  endtask

  task automatic run_pass(input logic [AW-1:0] w, input logic [AW-1:0] a, input logic acc,
                          input logic [PW-1:0] res, input int ready_delay,
                          input logic stale, input logic keep_done, input logic spurious);
    int s0;
    if (ready_delay == 0) psum_ready = 1'b1;
    issue_cmd(w, a, acc);
    if (spurious) begin
      cmd_w_base = 12'd999; cmd_a_base = 12'd777; cmd_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("busy_cmd_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
    end
    wait_stream_drained();
    s0 = start_cnt;
    repeat (3) @(negedge clk);
    check("no_start_before_load_done", start_cnt - s0, 0);
    cl_load_done = 1'b1;
    for (int i = 0; i < 20 && start_cnt == s0; i++) @(negedge clk);
    cl_load_done = 1'b0;
    if (stale) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("stale_done_ignored", psum_valid, 1'b0);
      end
      cl_compute_done = 1'b0;
    end
    repeat (2) @(negedge clk);
    cl_pe_out = res;
    psum_q.push_back(res);
    cl_compute_done = 1'b1;
    if (ready_delay == 0) begin
      for (int i = 0; i < 30 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) fail_now("pass_return_idle");
      psum_ready = 1'b0;
    end else begin
      for (int i = 0; i < 20 && !psum_valid; i++) @(negedge clk);
      if (!psum_valid) fail_now("psum_valid_wait");
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clk);
        check("stall_valid", psum_valid, 1'b1);
        check("stall_data", psum_data, res);
        check("stall_cmd_ready", cmd_ready, 1'b0);
      end
      @(posedge clk); #1 psum_ready = 1'b1;
      @(posedge clk); #1 psum_ready = 1'b0;
      @(negedge clk);
      check("idle_after_xfer", cmd_ready, 1'b1);
      check("valid_drop_after_xfer", psum_valid, 1'b0);
    end
    check("psum_drained", psum_q.size(), 0);
    check("start_pulses", start_cnt - s0, 1);
    if (!keep_done) cl_compute_done = 1'b0;
    last_result = res;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_acc = 1'b0; cmd_w_base = '0; cmd_a_base = '0;
    cl_load_done = 1'b0; cl_compute_done = 1'b0; cl_pe_out = '0; psum_ready = 1'b0;
    exp_pe_before = '0; last_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rd_en", glb_rd_en, 1'b0);
    check("rst_rd_addr", glb_rd_addr, '0);
    check("rst_en_w", cl_load_en_wght, 1'b0);
    check("rst_en_a", cl_load_en_act, 1'b0);
    check("rst_start", cl_start, 1'b0);
    check("rst_psum_valid", psum_valid, 1'b0);
    check("rst_psum_data", psum_data, '0);
    check("rst_pe_before", cl_pe_before, '0);
    check("rst_err", err_timeout, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic pass, psum_ready held high from before OUT.
    run_pass(12'd0, 12'd100, 1'b0, pack5(16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 0, 1'b0, 1'b0, 1'b0);
    // Accumulate with 10 cycles of backpressure; done left high; busy cmd ignored.
    run_pass(12'd200, 12'd300, 1'b1, pack5(16'd10, 16'd20, 16'd30, 16'd40, 16'd50), 10, 1'b0, 1'b1, 1'b1);
    // Stale compute_done from the previous pass must not trigger capture.
    run_pass(12'd50, 12'd60, 1'b0, pack5(16'd7, 16'd8, 16'd9, 16'd10, 16'd11), 2, 1'b1, 1'b0, 1'b0);
    run_pass(12'd70, 12'd400, 1'b1, pack5(16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF, 16'h0001), 1, 1'b0, 1'b0, 1'b0);

    // Timeout: cl_load_done never arrives.
    s0 = start_cnt;
    issue_cmd(12'd10, 12'd20, 1'b0);
    wait_stream_drained();
    n = 0;
    while (n < TMO + 100 && !err_timeout) begin
      @(negedge clk);
      n++;
    end
    check("timeout_flag", err_timeout, 1'b1);
    check("timeout_latency_in_window", (n >= TMO - 4 && n <= TMO + 4), 1'b1);
    check("timeout_no_start", start_cnt - s0, 0);
    check("timeout_idle", cmd_ready, 1'b1);
    run_pass(12'd5, 12'd6, 1'b0, pack5(16'd21, 16'd22, 16'd23, 16'd24, 16'd25), 1, 1'b0, 1'b0, 1'b0);

    // Reset while streaming activation word 7.
    issue_cmd(12'd30, 12'd500, 1'b1);
    n = 0;
    while (n < 100 && !(cl_load_en_act && cl_act_in == 16'd507)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("act_word7_wait");
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stream_q.delete();
    last_result = '0;
    @(negedge clk);
    check("mrst_en_w", cl_load_en_wght, 1'b0);
    check("mrst_en_a", cl_load_en_act, 1'b0);
    check("mrst_rd_en", glb_rd_en, 1'b0);
    check("mrst_cmd_ready", cmd_ready, 1'b1);
    check("mrst_psum_data", psum_data, '0);
    check("mrst_pe_before", cl_pe_before, '0);
    check("mrst_start", cl_start, 1'b0);

    // Address wrap: weights 4090..4095,0..8 and activations 4080..4095,0..8.
    run_pass(12'd4090, 12'd4080, 1'b1, pack5(16'd3, 16'd1, 16'd4, 16'd1, 16'd5), 3, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cluster_feeder.md
Name: cluster_feeder

Overview:
- Initiator/transmitter for the PE cluster load/compute interface.
- Per command, it performs these steps in order:
  - fetches weights, then activations, from a global-buffer (GLB) read port;
  - streams them serially onto the cluster's filt_in/act_in with the matching load enables;
  - pulses start and waits for completion;
  - captures the cluster's row-summed psum vector.
- Captured results go out over a valid/ready port.
- It optionally feeds the previous result back as the cluster's pe_before, for accumulation across passes.
- Sits between the GLB/top controller and one PE cluster.

Parameters:
- DATA_BITWIDTH, 16, word width of filt/act/psum lanes
- GLB_ADDR_BITWIDTH, 12, GLB read address width
- X_dim, 5, psum lanes in the cluster output vector
- W_COUNT, 15, weight words per pass (kernel_size*Y_dim)
- A_COUNT, 25, activation words per pass
- CAP_DELAY, 1, cycles from compute_done rising edge to sampling cl_pe_out
- TIMEOUT, 1023, max cycles waiting for load_done or compute_done

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  feeder idle and accepting a command
- cmd_w_base  in  GLB_ADDR_BITWIDTH  GLB address of first weight
- cmd_a_base  in  GLB_ADDR_BITWIDTH  GLB address of first activation
- cmd_acc  in  1  1: drive last result as pe_before; 0: drive zeros
- glb_rd_en  out  1  GLB read strobe
- glb_rd_addr  out  GLB_ADDR_BITWIDTH  GLB read address
- glb_rd_data  in  DATA_BITWIDTH  GLB data, valid 1 cycle after glb_rd_en
- cl_filt_in  out  DATA_BITWIDTH  weight word to cluster
- cl_act_in  out  DATA_BITWIDTH  activation word to cluster
- cl_load_en_wght  out  1  weight word valid this cycle
- cl_load_en_act  out  1  activation word valid this cycle
- cl_start  out  1  one-cycle compute start pulse
- cl_pe_before  out  DATA_BITWIDTH*X_dim  incoming psum vector to cluster
- cl_load_done  in  1  cluster load complete (level)
- cl_compute_done  in  1  cluster compute complete (level)
- cl_pe_out  in  DATA_BITWIDTH*X_dim  cluster registered psum vector
- psum_valid  out  1  result available
- psum_ready  in  1  consumer accepts result
- psum_data  out  DATA_BITWIDTH*X_dim  captured result
- err_timeout  out  1  sticky timeout flag; cleared by next accepted command

Behaviour:
- Reset: every output is 0 except cmd_ready=1. FSM goes to IDLE, counters clear, result register clears. Reset mid-operation aborts immediately; no further enables or start are issued.
- FSM states: IDLE, RD_W, RD_A, WAIT_LOAD, START, WAIT_COMP, CAPTURE, OUT.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid, latch bases and cmd_acc, clear err_timeout, and go to RD_W.
- RD_W:
  - glb_rd_en=1 for exactly W_COUNT consecutive cycles; glb_rd_addr = w_base + k for k=0..W_COUNT-1.
  - Then go to RD_A with no gap.
- RD_A:
  - Same as RD_W, for A_COUNT cycles, starting at a_base.
- Load-enable timing:
  - cl_load_en_wght/cl_load_en_act are the rd_en of each phase delayed by 1 cycle.
  - cl_filt_in/cl_act_in = glb_rd_data in that same cycle; they are 0 when their enable is low.
  - The two enables are never high together.
  - The last weight enable is immediately followed by the first act enable.
- After the last act enable goes low, go to WAIT_LOAD.
- WAIT_LOAD:
  - Wait for cl_load_done=1.
  - If it is not seen within TIMEOUT cycles, set err_timeout and return to IDLE.
- START:
  - cl_start=1 for one cycle; go to WAIT_COMP.
- WAIT_COMP:
  - Wait for a rising edge of cl_compute_done, using a registered previous value that is sampled from the START cycle onward.
  - A level already high at entry does not count.
  - TIMEOUT applies as in WAIT_LOAD.
- CAPTURE:
  - Wait CAP_DELAY cycles after the edge, then latch cl_pe_out into psum_data.
- OUT:
  - psum_valid=1 and psum_data is held stable until psum_ready=1.
  - Transfer occurs on a cycle with both high; then go to IDLE.
  - psum_ready asserted early, before OUT, has no effect.
- cl_pe_before:
  - Equals psum_data if the latched cmd_acc=1, else 0.
  - Registered from command accept onward and held constant through the pass.
- Address arithmetic: base+k wraps modulo 2^GLB_ADDR_BITWIDTH.
- Command handling: commands are not accepted outside IDLE; cmd_valid there is ignored.

Decomposition:
- Shared package:
  - FSM state encoding (localparams);
  - psum vector width constant DATA_BITWIDTH*X_dim;
  - count widths, $clog2 of W_COUNT, A_COUNT and TIMEOUT.
- One natural sub-module, glb_stream_reader: issues N sequential reads from a base address and produces the 1-cycle-delayed valid/data pair. It is instantiated once and reused for both phases via a length/base select.

Test Plan:
- Basic pass (W_COUNT=15, A_COUNT=25, GLB word at address a = a, w_base=0, a_base=100, cmd_acc=0):
  - 15 filt_in values 0..14 on consecutive cycles, then 25 act_in values 100..124 with no gap;
  - cl_start pulses once after load_done;
  - a compute_done edge with cl_pe_out=lanes {1,2,3,4,5} yields psum_data={1,2,3,4,5} CAP_DELAY cycles later.
- Backpressure: hold psum_ready=0 for 10 cycles in OUT -> psum_valid stays 1, psum_data stable, cmd_ready=0; psum_ready=1 -> IDLE the next cycle.
- Accumulate: second command with cmd_acc=1 -> cl_pe_before = previous result {1,2,3,4,5} throughout the pass; with cmd_acc=0 it is all zeros.
- Stale done: cl_compute_done held high from the previous pass -> no capture until it falls and rises again.
- Timeout: never assert cl_load_done -> err_timeout=1 after TIMEOUT cycles, cl_start never pulses, FSM returns to IDLE; the next command clears the flag.
- Reset mid-RD_A at activation word 7 -> the next cycle has all enables 0, cmd_ready=1, psum_data=0; wrap case w_base=4090 with width 12 reads 4090..4095, then 0..8.
